// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide engine: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one completion pulse per operation.
module multdiv_unit #(
    parameter int          DATA_W   = 32,
    parameter int          RD_W     = 5,
    parameter logic [2:0]  EXC_MULT = 3'd4,
    parameter logic [2:0]  EXC_DIV  = 3'd5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    input  logic [DATA_W-1:0] operandA,
    input  logic [DATA_W-1:0] operandB,
    input  logic [RD_W-1:0]   rd_in,
    output logic              busy,
    output logic [RD_W-1:0]   pending_rd,
    output logic              multdivRDY,
    output logic [RD_W-1:0]   multdiv_rd,
    output logic [DATA_W-1:0] result,
    output logic              md_excep,
    output logic [2:0]        md_rstatus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0]   ONE_W  = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [2*DATA_W-1:0] ONE_2W = {{(2*DATA_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0]   ZERO_W = {DATA_W{1'b0}};

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        mag = v[DATA_W-1] ? (~v + ONE_W) : v;
    endfunction

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                neg_q, neg_d;
    logic [RD_W-1:0]     rd_q, rd_d;
    // Multiply: {high accumulator, multiplier}; divide: {remainder, dividend/quotient}.
    logic [2*DATA_W-1:0] work_q, work_d;

    logic                busy_q, busy_d;
    logic [RD_W-1:0]     pend_q, pend_d;
    logic                rdy_q, rdy_d;
    logic [RD_W-1:0]     mrd_q, mrd_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                exc_q, exc_d;
    logic [2:0]          stat_q, stat_d;

    logic [DATA_W:0]     mul_sum_s;
    logic [2*DATA_W-1:0] mul_next_s;
    logic [2*DATA_W-1:0] prod_s;
    logic                mul_ovf_s;
    logic [DATA_W:0]     div_shift_s;
    logic [DATA_W:0]     div_trial_s;
    logic                div_bit_s;
    logic [DATA_W-1:0]   div_rem_s;
    logic [2*DATA_W-1:0] div_next_s;
    logic [DATA_W-1:0]   quo_s;

    assign mul_sum_s   = {1'b0, work_q[2*DATA_W-1:DATA_W]}
                       + (work_q[0] ? {1'b0, a_q} : {(DATA_W+1){1'b0}});
    assign mul_next_s  = {mul_sum_s, work_q[DATA_W-1:1]};
    assign prod_s      = neg_q ? (~mul_next_s + ONE_2W) : mul_next_s;
    // Signed product fits in 32 bits only if bits 63..31 are all equal.
    assign mul_ovf_s   = ~((&prod_s[2*DATA_W-1:DATA_W-1]) | ~(|prod_s[2*DATA_W-1:DATA_W-1]));

    assign div_shift_s = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
    assign div_trial_s = div_shift_s - {1'b0, b_q};
    assign div_bit_s   = ~div_trial_s[DATA_W];
    assign div_rem_s   = div_bit_s ? div_trial_s[DATA_W-1:0] : div_shift_s[DATA_W-1:0];
    assign div_next_s  = {div_rem_s, work_q[DATA_W-2:0], div_bit_s};
    assign quo_s       = neg_q ? (~div_next_s[DATA_W-1:0] + ONE_W) : div_next_s[DATA_W-1:0];

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        neg_d   = neg_q;
        rd_d    = rd_q;
        work_d  = work_q;
        busy_d  = busy_q;
        pend_d  = pend_q;
        rdy_d   = 1'b0;
        mrd_d   = mrd_q;
        res_d   = res_q;
        exc_d   = 1'b0;
        stat_d  = 3'd0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (ctrl_MULT) begin
                    state_d = S_MULT;
                    cnt_d   = 5'd0;
                    a_d     = mag(operandA);
                    b_d     = mag(operandB);
                    neg_d   = operandA[DATA_W-1] ^ operandB[DATA_W-1];
                    rd_d    = rd_in;
                    work_d  = {ZERO_W, mag(operandB)};
                    busy_d  = 1'b1;
                    pend_d  = rd_in;
                end else if (ctrl_DIV) begin
                    if (operandB == ZERO_W) begin
                        state_d = S_DONE;
                        rdy_d   = 1'b1;
                        mrd_d   = rd_in;
                        res_d   = ZERO_W;
                        exc_d   = 1'b1;
                        stat_d  = EXC_DIV;
                        busy_d  = 1'b0;
                        pend_d  = {RD_W{1'b0}};
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = 5'd0;
                        a_d     = mag(operandA);
                        b_d     = mag(operandB);
                        neg_d   = operandA[DATA_W-1] ^ operandB[DATA_W-1];
                        rd_d    = rd_in;
                        work_d  = {ZERO_W, mag(operandA)};
                        busy_d  = 1'b1;
                        pend_d  = rd_in;
                    end
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    pend_d  = {RD_W{1'b0}};
                end
            end
            S_MULT: begin
                work_d = mul_next_s;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    rdy_d   = 1'b1;
                    mrd_d   = rd_q;
                    res_d   = prod_s[DATA_W-1:0];
                    exc_d   = mul_ovf_s;
                    stat_d  = mul_ovf_s ? EXC_MULT : 3'd0;
                    busy_d  = 1'b0;
                    pend_d  = {RD_W{1'b0}};
                end else begin
                    state_d = S_MULT;
                end
            end
            S_DIV: begin
                work_d = div_next_s;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    rdy_d   = 1'b1;
                    mrd_d   = rd_q;
                    res_d   = quo_s;
                    busy_d  = 1'b0;
                    pend_d  = {RD_W{1'b0}};
                end else begin
                    state_d = S_DIV;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                pend_d  = {RD_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            a_q     <= ZERO_W;
            b_q     <= ZERO_W;
            neg_q   <= 1'b0;
            rd_q    <= {RD_W{1'b0}};
            work_q  <= {(2*DATA_W){1'b0}};
            busy_q  <= 1'b0;
            pend_q  <= {RD_W{1'b0}};
            rdy_q   <= 1'b0;
            mrd_q   <= {RD_W{1'b0}};
            res_q   <= ZERO_W;
            exc_q   <= 1'b0;
            stat_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            rd_q    <= rd_d;
            work_q  <= work_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            rdy_q   <= rdy_d;
            mrd_q   <= mrd_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            stat_q  <= stat_d;
        end
    end

    assign busy       = busy_q;
    assign pending_rd = pend_q;
    assign multdivRDY = rdy_q;
    assign multdiv_rd = mrd_q;
    assign result     = res_q;
    assign md_excep   = exc_q;
    assign md_rstatus = stat_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed scoreboard bench for multdiv_unit: expected results are queued at start
// and compared when the completion pulse appears.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] operandA, operandB;
    logic [4:0]  rd_in;
    logic        busy;
    logic [4:0]  pending_rd;
    logic        multdivRDY;
    logic [4:0]  multdiv_rd;
    logic [31:0] result;
    logic        md_excep;
    logic [2:0]  md_rstatus;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
        logic        exc;
        logic [2:0]  st;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    int   n_checks = 0;
    int   n_errors = 0;

    multdiv_unit dut (
        .clock      (clock),
        .reset      (reset),
        .ctrl_MULT  (ctrl_MULT),
        .ctrl_DIV   (ctrl_DIV),
        .operandA   (operandA),
        .operandB   (operandB),
        .rd_in      (rd_in),
        .busy       (busy),
        .pending_rd (pending_rd),
        .multdivRDY (multdivRDY),
        .multdiv_rd (multdiv_rd),
        .result     (result),
        .md_excep   (md_excep),
        .md_rstatus (md_rstatus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input bit is_mul, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] rd);
        exp_t   e;
        longint p;
        int     q;
        e.rd = rd;
        if (is_mul) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p != longint'(int'(p[31:0])));
            e.st  = e.exc ? 3'd4 : 3'd0;
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            e.st  = 3'd5;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000;
            e.exc = 1'b0;
            e.st  = 3'd0;
        end else begin
            q     = $signed(a) / $signed(b);
            e.res = q;
            e.exc = 1'b0;
            e.st  = 3'd0;
        end
        return e;
    endfunction

    // Starts an op in the current cycle (C0) and runs to its completion cycle.
    task automatic do_op(input bit is_mul, input bit both, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input int exp_lat, input int pulse_at);
        exp_t e;
        int   lat;
        bit   busy_ok;
        ctrl_MULT = is_mul;
        ctrl_DIV  = !is_mul || both;
        operandA  = a;
        operandB  = b;
        rd_in     = rd;
        sb.push_back(model(is_mul, a, b, rd));
        tick();
        ctrl_MULT = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            if (multdivRDY === 1'b1) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1 || pending_rd !== rd) busy_ok = 1'b0;
            ctrl_DIV = (n == pulse_at);
            operandA = $urandom;
            operandB = $urandom;
            rd_in    = 5'($urandom);
            tick();
        end
        ctrl_DIV = 1'b0;
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_during_op", 64'(busy_ok), 64'd1);
        check("busy_at_done", 64'(busy), 64'd0);
        check("pending_at_done", 64'(pending_rd), 64'd0);
        e = sb.pop_front();
        last_e = e;
        check("multdiv_rd", 64'(multdiv_rd), 64'(e.rd));
        check("result", 64'(result), 64'(e.res));
        check("md_excep", 64'(md_excep), 64'(e.exc));
        check("md_rstatus", 64'(md_rstatus), 64'(e.st));
    endtask

    // One cycle after completion: pulse and exception gone, result held.
    task automatic idle_check();
        tick();
        check("rdy_after", 64'(multdivRDY), 64'd0);
        check("excep_after", 64'(md_excep), 64'd0);
        check("rstatus_after", 64'(md_rstatus), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        check("result_hold", 64'(result), 64'(last_e.res));
        check("rd_hold", 64'(multdiv_rd), 64'(last_e.rd));
    endtask

    initial begin
        int rdy_seen;
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        operandA  = 32'd0;
        operandB  = 32'd0;
        rd_in     = 5'd0;
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rdy", 64'(multdivRDY), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_rd", 64'(multdiv_rd), 64'd0);
        reset = 1'b1;
        tick();

        do_op(1'b1, 1'b0, 32'd3, 32'hFFFF_FFFC, 5'd7, 33, 0);
        idle_check();
        do_op(1'b1, 1'b0, 32'h4000_0000, 32'd4, 5'd9, 33, 0);
        idle_check();
        do_op(1'b0, 1'b0, 32'd100, 32'hFFFF_FFF9, 5'd3, 33, 0);
        idle_check();
        do_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 33, 0);
        idle_check();
        do_op(1'b0, 1'b0, 32'd5, 32'd0, 5'd12, 1, 0);
        idle_check();
        // Both starts high (multiply wins), stray divide pulse, then back-to-back op.
        do_op(1'b1, 1'b1, 32'd6, 32'd2, 5'd2, 33, 10);
        do_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 5'd30, 33, 0);
        idle_check();
        do_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 33, 0);
        do_op(1'b0, 1'b0, 32'hFFFF_FF9C, 32'd7, 5'd5, 33, 0);
        idle_check();
        do_op(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0001_0000, 5'd17, 33, 0);
        idle_check();

        // Reset in C15 of a multiply aborts it.
        ctrl_MULT = 1'b1;
        operandA  = 32'd11;
        operandB  = 32'd13;
        rd_in     = 5'd21;
        tick();
        ctrl_MULT = 1'b0;
        for (int n = 1; n < 15; n++) tick();
        check("busy_before_abort", 64'(busy), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_pending", 64'(pending_rd), 64'd0);
        check("abort_rdy", 64'(multdivRDY), 64'd0);
        check("abort_rd", 64'(multdiv_rd), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_excep", 64'(md_excep), 64'd0);
        check("abort_rstatus", 64'(md_rstatus), 64'd0);
        rdy_seen = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (multdivRDY === 1'b1 || busy === 1'b1) rdy_seen++;
        end
        check("no_rdy_after_abort", 64'(rdy_seen), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
